// File: rtl/seq_gen_tx_pkg.sv
// rtl/seq_gen_tx_pkg.sv - shared state encodings and datapath widths for seq_gen_tx
package seq_gen_tx_pkg;

  localparam int PAT_W = 8;
  localparam int IDX_W = 3;
  localparam int REP_W = 4;
  localparam int GAP_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SEND = 2'b01,
    S_GAP  = 2'b10,
    S_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/seq_gen_shifter.sv
// rtl/seq_gen_shifter.sv - captured pattern, bit index and registered serial bit
module seq_gen_shifter
  import seq_gen_tx_pkg::*;
#(
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] pat,
  input  logic [IDX_W-1:0] len,
  output logic             bit_out,
  output logic             last
);

  logic [PAT_W-1:0] pat_q;
  logic [IDX_W-1:0] len_q;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;

  // Next index: count down, and restart at the top after bit 0 so a new repetition begins.
  always_comb begin
    idx_nxt = (idx == '0) ? len_q : idx - IDX_W'(1);
  end

  assign last = (idx == '0);

  // bit_out is the line itself: it holds a pattern bit only on edges that load or shift.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q   <= '0;
      len_q   <= '0;
      idx     <= '0;
      bit_out <= IDLE_LVL;
    end else if (load) begin
      pat_q   <= pat;
      len_q   <= len;
      idx     <= len;
      bit_out <= pat[len];
    end else if (shift) begin
      idx     <= idx_nxt;
      bit_out <= pat_q[idx_nxt];
    end else begin
      bit_out <= IDLE_LVL;
    end
  end

endmodule

// File: rtl/seq_gen_tx.sv
// rtl/seq_gen_tx.sv - repeating serial pattern transmitter with gap, abort and done pulse
module seq_gen_tx
  import seq_gen_tx_pkg::*;
#(
  parameter logic IDLE_LVL = 1'b1,
  parameter int   GAP      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic [IDX_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  output logic             dout,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  // Gap counter runs from GAP-1 down to 0, giving exactly GAP idle cycles.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  state_t           state, state_nxt;
  logic [REP_W-1:0] rep_cnt, rep_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             load, shift, last;

  seq_gen_shifter #(
    .IDLE_LVL (IDLE_LVL)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .shift   (shift),
    .pat     (pat),
    .len     (len),
    .bit_out (dout),
    .last    (last)
  );

  // Next-state and counter control; abort outranks every other transition.
  always_comb begin
    state_nxt = state;
    rep_nxt   = rep_cnt;
    gap_nxt   = gap_cnt;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          load      = 1'b1;
          rep_nxt   = reps;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_nxt = S_IDLE;
          rep_nxt   = '0;
        end else if (!last) begin
          shift = 1'b1;
        end else if (rep_cnt != '0) begin
          rep_nxt = rep_cnt - REP_W'(1);
          if (GAP > 0) begin
            state_nxt = S_GAP;
            gap_nxt   = GAP_LAST;
          end else begin
            shift = 1'b1;
          end
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_nxt = S_IDLE;
          rep_nxt   = '0;
          gap_nxt   = '0;
        end else if (gap_cnt == '0) begin
          shift     = 1'b1;
          state_nxt = S_SEND;
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and status flags are all registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      rep_cnt <= '0;
      gap_cnt <= '0;
      frame   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      rep_cnt <= rep_nxt;
      gap_cnt <= gap_nxt;
      frame   <= (state_nxt == S_SEND);
      busy    <= (state_nxt != S_IDLE);
      done    <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_seq_gen_tx.sv
// tb/tb_seq_gen_tx.sv - self-checking bench for seq_gen_tx over three GAP/IDLE_LVL variants
module tb_seq_gen_tx;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] pat;
  logic [2:0] len;
  logic [3:0] reps;
  logic       dout_a, frame_a, busy_a, done_a;
  logic       dout_b, frame_b, busy_b, done_b;
  logic       dout_c, frame_c, busy_c, done_c;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  seq_gen_tx #(.IDLE_LVL(1'b1), .GAP(1)) dut_a (
    .clk(clk), .rst(rst), .start(start), .pat(pat), .len(len), .reps(reps), .abort(abort),
    .dout(dout_a), .frame(frame_a), .busy(busy_a), .done(done_a)
  );
  seq_gen_tx #(.IDLE_LVL(1'b1), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .start(start), .pat(pat), .len(len), .reps(reps), .abort(abort),
    .dout(dout_b), .frame(frame_b), .busy(busy_b), .done(done_b)
  );
  seq_gen_tx #(.IDLE_LVL(1'b0), .GAP(3)) dut_c (
    .clk(clk), .rst(rst), .start(start), .pat(pat), .len(len), .reps(reps), .abort(abort),
    .dout(dout_c), .frame(frame_c), .busy(busy_c), .done(done_c)
  );

  // Expected {dout, frame, busy, done} k cycles after the capturing edge.
  function automatic logic [3:0] model_at(int gap, logic idl, logic [7:0] p, int l, int r, int k);
    int period, span, off;
    period = l + 1 + gap;
    span   = (r + 1) * (l + 1) + r * gap;
    if (k < span) begin
      off = k % period;
      if (off <= l) return {p[l - off], 3'b110};
      return {idl, 3'b010};
    end
    if (k == span) return {idl, 3'b011};
    return {idl, 3'b000};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(string name);
    check({name, "/a"}, {dout_a, frame_a, busy_a, done_a}, 4'b1000);
    check({name, "/b"}, {dout_b, frame_b, busy_b, done_b}, 4'b1000);
    check({name, "/c"}, {dout_c, frame_c, busy_c, done_c}, 4'b0000);
  endtask

  // One transfer from IDLE; inputs are scrambled after capture, optional start re-pulse at mid_k.
  task automatic run_xfer(string name, logic [7:0] p, logic [2:0] l, logic [3:0] r, int mid_k,
                          output int busy_cnt);
    int la, ra, kmax;
    la = int'(l);
    ra = int'(r);
    pat = p; len = l; reps = r; start = 1'b1;
    tick();
    start = 1'b0;
    pat  = 8'($urandom);
    len  = 3'($urandom);
    reps = 4'($urandom);
    busy_cnt = 0;
    kmax = (ra + 1) * (la + 1) + 3 * ra + 1;
    for (int k = 0; k <= kmax; k++) begin
      check($sformatf("%s/a k=%0d", name, k), {dout_a, frame_a, busy_a, done_a}, model_at(1, 1'b1, p, la, ra, k));
      check($sformatf("%s/b k=%0d", name, k), {dout_b, frame_b, busy_b, done_b}, model_at(0, 1'b1, p, la, ra, k));
      check($sformatf("%s/c k=%0d", name, k), {dout_c, frame_c, busy_c, done_c}, model_at(3, 1'b0, p, la, ra, k));
      if (busy_a) busy_cnt++;
      if (k == mid_k) begin
        start = 1'b1;
        pat   = ~p;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] pat;
    logic [2:0] len;
    logic [3:0] reps;
    int         mid_k;
    int         busy_a;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int bc, mk, la, ra;
    logic [7:0] p;
    logic [2:0] l;
    logic [3:0] r;

    vecs[0] = '{8'h03, 3'd2, 4'd0,  -1, 4};
    vecs[1] = '{8'h03, 3'd2, 4'd1,  -1, 8};
    vecs[2] = '{8'hA5, 3'd7, 4'd1,  -1, 18};
    vecs[3] = '{8'hA5, 3'd7, 4'd0,   1, 9};
    vecs[4] = '{8'h80, 3'd0, 4'd0,  -1, 2};
    vecs[5] = '{8'h6C, 3'd3, 4'd15, -1, 80};

    rst = 1'b0; start = 1'b0; abort = 1'b0; pat = '0; len = '0; reps = '0;
    tick();
    tick();
    check_idle("reset");
    rst = 1'b1;
    tick();
    check_idle("post_reset");

    for (int i = 0; i < 6; i++) begin
      run_xfer($sformatf("vec%0d", i), vecs[i].pat, vecs[i].len, vecs[i].reps, vecs[i].mid_k, bc);
      check($sformatf("vec%0d busy_cycles", i), bc, vecs[i].busy_a);
    end

    // abort during the second bit of an 8-bit pattern
    pat = 8'hC3; len = 3'd7; reps = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("abort first_bit", {dout_a, frame_a, busy_a, done_a}, 4'b1110);
    tick();
    check("abort second_bit", {dout_a, frame_a, busy_a, done_a}, 4'b1110);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 3; i++) check_idle($sformatf("after_abort%0d", i));
    run_xfer("post_abort", 8'h5A, 3'd3, 4'd1, -1, bc);

    // abort and start together in IDLE
    pat = 8'hFF; len = 3'd7; reps = 4'd0; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_idle("abort_start0");
    tick();
    check_idle("abort_start1");

    // reset while dut_a sits in its gap cycle; start held during reset is ignored
    pat = 8'h03; len = 3'd2; reps = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("rst_gap in_gap", {dout_a, frame_a, busy_a, done_a}, 4'b1010);
    rst = 1'b0; start = 1'b1;
    tick();
    check_idle("rst_gap0");
    tick();
    check_idle("rst_gap1");
    rst = 1'b1; start = 1'b0;
    tick();
    check_idle("rst_gap_release");
    run_xfer("post_rst", 8'h96, 3'd5, 4'd2, -1, bc);

    // randomized transfers against the reference model
    for (int i = 0; i < 20; i++) begin
      p  = 8'($urandom);
      l  = 3'($urandom_range(0, 7));
      r  = 4'($urandom_range(0, 15));
      la = int'(l);
      ra = int'(r);
      mk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, (ra + 1) * (la + 1) - 1)) : -1;
      run_xfer($sformatf("rnd%0d", i), p, l, r, mk, bc);
      check($sformatf("rnd%0d busy_cycles", i), bc, (ra + 1) * (la + 1) + ra + 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
